// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Provides the controller state encoding, the default operand width and
// the step-counter width helper used by seq_divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 25;

  // Bits needed to count 0..width-1; never less than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports: rem_in (partial remainder, WIDTH+1 bits), dvd_bit (next dividend bit, MSB first),
//        divisor; rem_out (next partial remainder), q_bit (quotient bit produced).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  // The partial remainder always stays below the divisor, so its MSB is
  // never significant when shifting.
  logic             unused_rem_msb;

  assign shifted        = {rem_in[WIDTH-1:0], dvd_bit};
  // One extra bit so the top bit of the difference is the borrow.
  assign trial          = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit          = ~trial[WIDTH+1];
  assign rem_out        = q_bit ? trial[WIDTH:0] : shifted;
  assign unused_rem_msb = rem_in[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start/dividend/divisor (sampled when not busy),
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero (held until next completion).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic             accept;
  logic             last_step;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] dvd_sr;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_sr;

  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  // The oldest quotient bit shifts out of the register unread; the final
  // quotient is assembled from the low bits plus the bit produced this cycle.
  logic             unused_quo_msb;

  assign unused_quo_msb = quo_sr[WIDTH-1];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_r),
    .dvd_bit (dvd_sr[WIDTH-1]),
    .divisor (divisor_r),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DONE behaves like IDLE for acceptance, which allows
  // back-to-back operations without an idle gap.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_STEP) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      divisor_r   <= '0;
      dvd_sr      <= '0;
      rem_r       <= '0;
      quo_sr      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt       <= '0;
      divisor_r <= divisor;
      dvd_sr    <= dividend;
      rem_r     <= '0;
      quo_sr    <= '0;
      // Divide-by-zero finishes immediately with a saturated quotient.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      dvd_sr <= {dvd_sr[WIDTH-2:0], 1'b0};
      rem_r  <= rem_nxt;
      quo_sr <= {quo_sr[WIDTH-2:0], q_bit};
      if (last_step) begin
        quotient    <= {quo_sr[WIDTH-2:0], q_bit};
        remainder   <= rem_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=25 and WIDTH=5.
// Expected results are queued on each accepted start and compared on each done pulse.
module tb_seq_divider;

  localparam int W25 = 25;
  localparam int W5  = 5;

  typedef struct {
    longint unsigned q;
    longint unsigned r;
    bit              dz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=25 instance signals
  logic           rst25, s25;
  logic [W25-1:0] a25, b25, quo25, rem25;
  logic           busy25, done25, dz25;

  // WIDTH=5 instance signals
  logic           rst5, s5;
  logic [W5-1:0]  a5, b5, quo5, rem5;
  logic           busy5, done5, dz5;

  seq_divider #(.WIDTH(W25)) u_dut25 (
    .clk         (clk),
    .rst         (rst25),
    .start       (s25),
    .dividend    (a25),
    .divisor     (b25),
    .busy        (busy25),
    .done        (done25),
    .quotient    (quo25),
    .remainder   (rem25),
    .div_by_zero (dz25)
  );

  seq_divider #(.WIDTH(W5)) u_dut5 (
    .clk         (clk),
    .rst         (rst5),
    .start       (s5),
    .dividend    (a5),
    .divisor     (b5),
    .busy        (busy5),
    .done        (done5),
    .quotient    (quo5),
    .remainder   (rem5),
    .div_by_zero (dz5)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q25[$];
  exp_t q5[$];

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input longint unsigned a, input longint unsigned b, input int w);
    exp_t e;
    if (b == 0) begin
      e.q  = (64'd1 << w) - 1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboards: pop and compare on every done pulse.
  always @(negedge clk) begin : mon25
    exp_t e;
    if (done25) begin
      if (q25.size() == 0) chk("done25_unexpected", 1, 0);
      else begin
        e = q25.pop_front();
        chk("quo25", quo25, e.q);
        chk("rem25", rem25, e.r);
        chk("dz25", dz25, e.dz);
      end
    end
  end

  always @(negedge clk) begin : mon5
    exp_t e;
    if (done5) begin
      if (q5.size() == 0) chk("done5_unexpected", 1, 0);
      else begin
        e = q5.pop_front();
        chk("quo5", quo5, e.q);
        chk("rem5", rem5, e.r);
        chk("dz5", dz5, e.dz);
        chk("id5", longint'(quo5) * longint'(b5) + longint'(rem5), a5);
      end
    end
  end

  // Entered at the first negedge after the accepting edge (0 edges elapsed).
  task automatic wait_done25(input string tag, input int exp_lat);
    int j = 0;
    while (!done25 && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk({tag, "_lat"}, done25 ? j : 999, exp_lat);
  endtask

  task automatic run_op25(input string tag, input logic [W25-1:0] a, input logic [W25-1:0] b);
    @(negedge clk);
    s25 = 1'b1; a25 = a; b25 = b;
    q25.push_back(model(a, b, W25));
    @(negedge clk);
    s25 = 1'b0;
    chk({tag, "_busy"}, busy25, (b != 0));
    wait_done25(tag, (b == 0) ? 0 : W25);
  endtask

  task automatic run_op5(input logic [W5-1:0] a, input logic [W5-1:0] b);
    int j = 0;
    @(negedge clk);
    s5 = 1'b1; a5 = a; b5 = b;
    q5.push_back(model(a, b, W5));
    @(negedge clk);
    s5 = 1'b0;
    while (!done5 && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("lat5", done5 ? j : 999, W5);
  endtask

  initial begin
    int  j;
    bit  seen;

    rst25 = 1'b1; s25 = 1'b0; a25 = '0; b25 = '0;
    rst5  = 1'b1; s5  = 1'b0; a5  = '0; b5  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy25, 0);
    chk("rst_done", done25, 0);
    chk("rst_quo", quo25, 0);
    chk("rst_rem", rem25, 0);
    chk("rst_dz", dz25, 0);
    rst25 = 1'b0;
    rst5  = 1'b0;

    // Basic operation, then results held through IDLE.
    run_op25("d100_7", 25'd100, 25'd7);
    repeat (3) @(negedge clk);
    chk("hold_quo", quo25, 14);
    chk("hold_rem", rem25, 2);
    chk("hold_busy", busy25, 0);

    run_op25("max_1", 25'd33554431, 25'd1);
    run_op25("d5_9", 25'd5, 25'd9);
    run_op25("dz", 25'd1234, 25'd0);
    @(negedge clk);
    chk("dz_pulse_once", done25, 0);

    // start held while busy is ignored; start in the DONE cycle is accepted.
    @(negedge clk);
    s25 = 1'b1; a25 = 25'd100; b25 = 25'd7;
    q25.push_back(model(100, 7, W25));
    @(negedge clk);
    s25 = 1'b0;
    j = 0;
    while (j < 100) begin
      if (done25) break;
      @(negedge clk);
      j++;
      if (done25) break;
      if (j >= 3 && j <= 10) begin
        s25 = 1'b1; a25 = 25'd50; b25 = 25'd5;
      end else begin
        s25 = 1'b0;
      end
    end
    chk("b2b_first_lat", done25 ? j : 999, W25);
    s25 = 1'b1; a25 = 25'd50; b25 = 25'd5;
    q25.push_back(model(50, 5, W25));
    @(negedge clk);
    s25 = 1'b0;
    chk("b2b_busy", busy25, 1);
    wait_done25("b2b_second", W25);

    // Reset in the middle of a run discards it.
    @(negedge clk);
    s25 = 1'b1; a25 = 25'd100; b25 = 25'd7;
    q25.push_back(model(100, 7, W25));
    @(negedge clk);
    s25 = 1'b0;
    repeat (12) @(negedge clk);
    rst25 = 1'b1;
    @(negedge clk);
    q25.delete();
    chk("mrst_busy", busy25, 0);
    chk("mrst_done", done25, 0);
    chk("mrst_quo", quo25, 0);
    chk("mrst_rem", rem25, 0);
    chk("mrst_dz", dz25, 0);
    rst25 = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done25) seen = 1'b1;
    end
    chk("mrst_no_done", seen, 0);

    // Exhaustive nonzero-divisor sweep at WIDTH=5.
    for (int a = 0; a < 32; a++) begin
      for (int b = 1; b < 32; b++) begin
        run_op5(W5'(a), W5'(b));
      end
    end
    @(negedge clk);
    chk("sb25_empty", q25.size(), 0);
    chk("sb5_empty", q5.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
